// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory: size codes, FSM states, lane logic.
// Latency: pure combinational functions, no state.
// Backpressure: not applicable (package only).
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_IDLE  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // Illegal size code or an access that does not sit on its natural boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  // Drop right-aligned store data into the addressed lane, keeping the other bytes.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] w;
    w = old_word;
    case (size)
      SZ_BYTE: w[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (off[1]) w[31:16] = wdata[15:0];
        else        w[15:0]  = wdata[15:0];
      end
      SZ_WORD: w = wdata;
      default: w = old_word;
    endcase
    return w;
  endfunction

  // Pull the addressed lane out of a word and sign/zero extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: r = {{16{~is_unsigned & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port 32-bit word array with one shared address for read and write.
// Latency: write commits on the rising edge, read data is combinational from addr.
// Backpressure: none, always accepts.
module dmem_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Synchronous write port; contents are not reset (the controller sweeps them).
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked data memory: clear sweep after reset, byte/half/word stores, extended loads, error flag.
// Latency: response strobe 1+WAIT_STATES edges after accept (accept edge counted); spacing 2+WAIT_STATES.
// Backpressure: req_ready only in IDLE; optional store trace under DMEM_CTRL_TRACE_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2     = 12,
  parameter int WAIT_STATES    = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam state_t     RESET_ST  = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic [3:0]            wait_cnt;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_err;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [31:0]           ram_rdata;
  logic [31:0]           ram_wdata;
  logic [31:0]           merged;
  logic                  ram_we;

  // Upper address bits wrap and the PC only feeds the optional trace.
  logic unused_bits;
  assign unused_bits = ^{req_pc, req_addr[31:DEPTH_LOG2+2]};

  assign req_idx   = req_addr[DEPTH_LOG2+1:2];
  assign accept    = req_valid && req_ready;
  assign req_err   = misaligned(req_size, req_addr[1:0]);
  assign ram_addr  = (state == ST_CLEAR) ? clr_idx : req_idx;
  assign merged    = lane_merge(ram_rdata, req_wdata, req_size, req_addr[1:0]);
  assign ram_wdata = (state == ST_CLEAR) ? '0 : merged;
  // Gated by reset so a store racing a reset assertion never lands.
  assign ram_we    = !reset && ((state == ST_CLEAR) || (accept && req_we && !req_err));

  dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register; reset aborts any sweep or pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_ST;
    else       state <= state_nxt;
  end

  // Sweep index, wait counter and the latched response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_idx  <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
      if (accept) begin
        wait_cnt <= WAIT_INIT;
        err_q    <= req_err;
        rdata_q  <= (req_err || req_we) ? '0
                    : load_extract(ram_rdata, req_size, req_addr[1:0], req_unsigned);
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // Next-state and handshake outputs; reset forces the not-ready/busy view.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    case (state)
      ST_CLEAR: if (clr_idx == {DEPTH_LOG2{1'b1}}) state_nxt = ST_IDLE;
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT:  if (wait_cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = RESET_ST;
    endcase
    if (reset) begin
      req_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
    end
  end

  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;

`ifdef DMEM_CTRL_TRACE_EN
  // Store trace: one line per committed or rejected store.
  always @(posedge clk) begin
    if (!reset && accept && req_we) begin
      if (req_err) $display("%0t@%h: misaligned addr", $time, req_pc);
      else         $display("%0t@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
    end
  end
`else
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: two instances (0 and 3 wait states) sharing reset and request fields.
// Latency: expected responses queued at issue, popped by per-instance monitors on the falling edge.
// Backpressure: requests wait (bounded) for req_ready before asserting req_valid.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int W1 = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SZ_WORD;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;

  logic        ready0, ready1, rspv0, rspv1, err0, err1, busy0, busy1;
  logic [31:0] rdata0, rdata1;

  int n_cmp = 0, n_bad = 0;
  int rsp_cnt0 = 0, rsp_cnt1 = 0;
  logic [32:0] q0[$], q1[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_LOG2(4), .WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rspv0), .rsp_rdata(rdata0),
    .rsp_err(err0), .busy(busy0)
  );

  dmem_ctrl #(.DEPTH_LOG2(4), .WAIT_STATES(W1), .CLEAR_ON_RESET(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc), .rsp_valid(rspv1), .rsp_rdata(rdata1),
    .rsp_err(err1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic ready_of(input bit s);
    return s ? ready1 : ready0;
  endfunction
  function automatic logic rspv_of(input bit s);
    return s ? rspv1 : rspv0;
  endfunction
  function automatic logic [31:0] rdata_of(input bit s);
    return s ? rdata1 : rdata0;
  endfunction
  function automatic int cnt_of(input bit s);
    return s ? rsp_cnt1 : rsp_cnt0;
  endfunction

  // Response monitor, instance 0.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rspv0 === 1'b1) begin
      if (q0.size() == 0) check("unexpected_rsp0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("rdata0", rdata0, e[31:0]);
        check("err0", {31'd0, err0}, {31'd0, e[32]});
      end
      rsp_cnt0++;
    end
  end

  // Response monitor, instance 1.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rspv1 === 1'b1) begin
      if (q1.size() == 0) check("unexpected_rsp1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("rdata1", rdata1, e[31:0]);
        check("err1", {31'd0, err1}, {31'd0, e[32]});
      end
      rsp_cnt1++;
    end
  end

  task automatic wait_ready(input bit s);
    int n;
    n = 0;
    while (ready_of(s) !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input bit s, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input bit exp_e, input bit lat_chk);
    int n, start;
    wait_ready(s);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_pc = 32'h0040_0000 + addr;
    start = cnt_of(s);
    if (s) q1.push_back({exp_e, exp_d}); else q0.push_back({exp_e, exp_d});
    if (s) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    if (lat_chk) begin
      n = 1;
      while (rspv_of(s) !== 1'b1 && n < 50) begin
        check("ready_low_wait", {31'd0, ready_of(s)}, 32'd0);
        @(posedge clk); #1; n++;
      end
      check("latency", 32'(n), s ? 32'(1 + W1) : 32'd1);
      check("ready_low_resp", {31'd0, ready_of(s)}, 32'd0);
    end
    n = 0;
    while (cnt_of(s) == start && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("rdata_idle_zero", rdata_of(s), 32'd0);
  endtask

  task automatic release_and_sweep();
    int n;
    reset = 1'b0;
    n = 0;
    while (ready0 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("clear_len", 32'(n), 32'd16);
    check("clear_len1", {31'd0, ready1}, 32'd1);
    check("busy_idle", {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", {31'd0, ready0}, 32'd0);
    check("rst_rspv0",  {31'd0, rspv0},  32'd0);
    check("rst_busy0",  {31'd0, busy0},  32'd1);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_err0",   {31'd0, err0},   32'd0);
    check("rst_ready1", {31'd0, ready1}, 32'd0);
    check("rst_busy1",  {31'd0, busy1},  32'd1);
    release_and_sweep();

    for (int i = 0; i < 16; i++)
      do_req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'(i * 4), '0, 32'd0, 1'b0, i == 0);

    do_req(0, 1, SZ_WORD, 0, 32'h10, 32'h1122_3344, 32'd0, 0, 0);
    do_req(0, 1, SZ_BYTE, 0, 32'h12, 32'h0000_00AA, 32'd0, 0, 0);
    do_req(0, 0, SZ_WORD, 0, 32'h10, 32'd0, 32'h11AA_3344, 0, 0);

    do_req(0, 1, SZ_WORD, 0, 32'h20, 32'h0000_80F0, 32'd0, 0, 0);
    do_req(0, 0, SZ_HALF, 0, 32'h20, 32'd0, 32'hFFFF_80F0, 0, 0);
    do_req(0, 0, SZ_HALF, 1, 32'h20, 32'd0, 32'h0000_80F0, 0, 0);
    do_req(0, 0, SZ_BYTE, 0, 32'h20, 32'd0, 32'hFFFF_FFF0, 0, 0);
    do_req(0, 0, SZ_BYTE, 1, 32'h21, 32'd0, 32'h0000_0080, 0, 0);

    do_req(0, 0, SZ_WORD, 0, 32'h22, 32'd0, 32'd0, 1, 0);
    do_req(0, 1, SZ_HALF, 0, 32'h23, 32'h0000_1234, 32'd0, 1, 0);
    do_req(0, 1, SZ_ILL,  0, 32'h20, 32'hDEAD_BEEF, 32'd0, 1, 0);
    do_req(0, 0, SZ_WORD, 0, 32'h20, 32'd0, 32'h0000_80F0, 0, 0);

    do_req(0, 1, SZ_HALF, 0, 32'h22, 32'h0000_BEEF, 32'd0, 0, 0);
    do_req(0, 0, SZ_WORD, 0, 32'h20, 32'd0, 32'hBEEF_80F0, 0, 0);
    do_req(0, 0, SZ_WORD, 0, 32'h60, 32'd0, 32'hBEEF_80F0, 0, 0);
    do_req(0, 0, SZ_HALF, 0, 32'h22, 32'd0, 32'hFFFF_BEEF, 0, 0);
    do_req(0, 0, SZ_BYTE, 1, 32'h23, 32'd0, 32'h0000_00BE, 0, 0);

    do_req(1, 1, SZ_WORD, 0, 32'h08, 32'hCAFE_F00D, 32'd0, 0, 1);
    do_req(1, 0, SZ_WORD, 0, 32'h08, 32'd0, 32'hCAFE_F00D, 0, 1);

    // Load on the wait-state instance, aborted by reset during WAIT.
    wait_ready(1'b1);
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h08;
    start = rsp_cnt1;
    valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    check("wait_busy", {31'd0, busy1}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready1}, 32'd0);
    check("abort_busy",  {31'd0, busy1},  32'd1);
    repeat (2) @(posedge clk);
    #1;
    release_and_sweep();
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(rsp_cnt1), 32'(start));

    do_req(1, 0, SZ_WORD, 0, 32'h08, 32'd0, 32'd0, 0, 0);
    do_req(0, 0, SZ_WORD, 0, 32'h10, 32'd0, 32'd0, 0, 0);
    do_req(0, 0, SZ_WORD, 0, 32'h20, 32'd0, 32'd0, 0, 0);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, handshaked data memory for the MIPS datapath; the next generation of the single-cycle data RAM.
- Adds a valid/ready request channel and a one-cycle response pulse.
- Adds configurable wait states, byte/half/word stores via lane masks, and sign/zero-extended loads.
- Adds misalignment detection and a sequential RAM-clear sweep after reset.
- Sits between the MEM stage and the word-addressed RAM array.

Parameters:
- DEPTH_LOG2, 12: RAM holds 2**DEPTH_LOG2 32-bit words.
- WAIT_STATES, 0: extra cycles between accept and response; legal range 0..15.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = skip the sweep.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  load zero-extends (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_pc  in  32  PC of the issuing instruction (trace only)
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned or illegal
- busy  out  1  clear sweep or operation in flight

Behaviour:
- Single clock domain. reset is asynchronous, active-high.
- While reset is high: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1, clear index=0, wait counter=0.
- On release, state = CLEAR if CLEAR_ON_RESET, else IDLE.
- Word index = req_addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size.
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Writes 0 to ram[clr_idx] each cycle and increments clr_idx.
  - After the write of index DEPTH-1, moves to IDLE. The sweep lasts exactly 2**DEPTH_LOG2 cycles.
  - req_ready=0, busy=1.
- IDLE:
  - req_ready=1, busy=0.
  - A request is accepted on a rising edge with req_valid && req_ready. At acceptance:
    - Error check: error if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
    - Error: RAM untouched, err flag latched, data latched as 0.
    - Store, no error: single RMW into the addressed word, same edge.
      - Byte lane = addr[1:0]; half lane = addr[1] (1 = bits 31:16).
      - Unselected bytes are preserved.
    - Load, no error: whole word latched, then extracted and extended.
      - Byte lane: bit 7 sign-extends unless req_unsigned.
      - Half lane: bit 15 sign-extends unless req_unsigned.
      - Word loads pass through unchanged.
  - Next state: WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES), else RESP.
- WAIT:
  - Counter decrements every cycle; moves to RESP when it reaches 1.
  - req_ready=0, busy=1.
- RESP:
  - rsp_valid=1 for exactly one cycle with rsp_rdata and rsp_err; then IDLE.
  - req_ready=0 in RESP, so there is no back-to-back accept.
  - Cycles from accept edge to rsp_valid high = 1 + WAIT_STATES. Minimum request spacing = 2 + WAIT_STATES cycles.
- Outputs outside RESP: rsp_rdata and rsp_err hold 0; they never show X.
- Load of a word stored on an earlier transaction returns the new data.
- Reset asserted mid-WAIT or mid-CLEAR aborts at once. Pending response is dropped; the sweep restarts from index 0.
- Store and reset rising in the same cycle: the store is discarded.
- req_valid during CLEAR, WAIT or RESP is ignored. The requester holds it until req_ready.

Optional Feature:
- Macro DMEM_CTRL_TRACE_EN.
- Defined: every committed store prints "time@pc: *wordaddr <= mergedword", with wordaddr = {addr[31:2],2'b00}. Errored stores print "time@pc: misaligned addr".
- Undefined: no $display; RTL is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - functions: lane-merge (old word, wdata, size, addr[1:0]) and load-extract (word, size, addr[1:0], unsigned).
- One sub-module dmem_ram: single-port 32-bit array, synchronous write, asynchronous read, DEPTH_LOG2 parameter. The FSM and clear sweep stay in dmem_ctrl.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH_LOG2=4 -> req_ready rises exactly 16 cycles after release; word loads at 0x0..0x3C return 0.
- sw 0x11223344 @0x10; sb 0xAA @0x12; lw @0x10 -> rdata 0x11AA3344, err=0.
- Word 0x000080F0 at 0x20: lh @0x20 -> 0xFFFF80F0; lhu @0x20 -> 0x000080F0; lb @0x20 -> 0xFFFFFFF0; lbu @0x21 -> 0x00000080.
- lw @0x22 and sh @0x23 -> rsp_err=1, rdata=0, memory unchanged (lw @0x20 still 0x000080F0).
- WAIT_STATES=3 -> rsp_valid exactly 4 cycles after the accept edge; req_ready low for those cycles plus the RESP cycle.
- Reset pulse during WAIT of a load -> no rsp_valid; CLEAR restarts; earlier stored word reads back 0 after the sweep.
